// File: rtl/systolic_ctrl_pkg.sv
// Shared types and sizing helpers for the systolic array sequencer.
// Optional performance counters are enabled with SYSTOLIC_CTRL_PERF_EN.
package systolic_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CLEAR = 3'd1,
      ST_FEED  = 3'd2,
      ST_DRAIN = 3'd3,
      ST_WB    = 3'd4,
      ST_DONE  = 3'd5
   } state_t;

   // Weight precision codes understood by the FP-INT PEs.
   localparam logic [3:0] PREC_INT1 = 4'd1;
   localparam logic [3:0] PREC_INT2 = 4'd2;
   localparam logic [3:0] PREC_INT4 = 4'd4;
   localparam logic [3:0] PREC_INT8 = 4'd8;

   function automatic int ACC_SEL_W(input int n);
      return (n * n > 1) ? $clog2(n * n) : 1;
   endfunction

   // Cycles for the last operand to ripple through the skewed array.
   function automatic int drain_len(input int n, input int pe_lat);
      return 2 * n - 1 + pe_lat;
   endfunction

endpackage

// File: rtl/systolic_ctrl_if.sv
// Command, operand-read and result-stream signals of the systolic sequencer.
// SYSTOLIC_CTRL_PERF_EN adds the perf_cyc/perf_stall counters.
interface systolic_ctrl_if
   import systolic_pkg::*;
#(
   parameter int N       = 2,
   parameter int K_WIDTH = 8
);
   localparam int AW = ACC_SEL_W(N);

   logic               start;
   logic [K_WIDTH-1:0] k_len;
   logic [3:0]         precision;
   logic [4:0]         exp_set;
   logic [3:0]         prec_cfg;
   logic [4:0]         exp_cfg;
   logic               busy;
   logic               done;
   logic               acc_clr;
   logic               rd_en;
   logic [K_WIDTH-1:0] rd_addr;
   logic [N-1:0]       row_valid;
   logic [N-1:0]       col_valid;
   // Result stream: a word moves on every cycle with out_valid & out_ready;
   // out_valid never drops and acc_sel never changes until that transfer.
   logic               out_valid;
   logic               out_ready;
   logic [AW-1:0]      acc_sel;
   state_t             dbg_state;
`ifdef SYSTOLIC_CTRL_PERF_EN
   logic [31:0]        perf_cyc;
   logic [31:0]        perf_stall;
`endif

   modport master (
      output start, k_len, precision, exp_set, out_ready,
      input  prec_cfg, exp_cfg, busy, done, acc_clr, rd_en, rd_addr,
             row_valid, col_valid, out_valid, acc_sel, dbg_state
`ifdef SYSTOLIC_CTRL_PERF_EN
      , input perf_cyc, perf_stall
`endif
   );

   modport slave (
      input  start, k_len, precision, exp_set, out_ready,
      output prec_cfg, exp_cfg, busy, done, acc_clr, rd_en, rd_addr,
             row_valid, col_valid, out_valid, acc_sel, dbg_state
`ifdef SYSTOLIC_CTRL_PERF_EN
      , output perf_cyc, perf_stall
`endif
   );

endinterface

// File: rtl/systolic_ctrl_skew_shift.sv
// N-tap delay line: tap i is the input delayed by 1+i cycles, giving the
// diagonal operand-valid wavefront into the array.
module skew_shift #(
   parameter int N = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_din,
   output logic [N-1:0] o_taps
);

   logic [N-1:0] r_taps;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_taps <= '0;
      end else begin
         r_taps[0] <= i_din;
         for (int i = 1; i < N; i++) r_taps[i] <= r_taps[i-1];
      end
   end

   assign o_taps = r_taps;

endmodule

// File: rtl/systolic_ctrl.sv
// GEMM sequencer for the N x N systolic MAC array: clear, feed K operands,
// drain, then unload N*N accumulators. SYSTOLIC_CTRL_PERF_EN adds perf counters.
module systolic_ctrl
   import systolic_pkg::*;
#(
   parameter int N       = 2,
   parameter int K_WIDTH = 8,
   parameter int PE_LAT  = 2
) (
   input logic           clk,
   input logic           rst,
   systolic_ctrl_if.slave bus
);

   localparam int             AW         = ACC_SEL_W(N);
   localparam int             DRAIN      = drain_len(N, PE_LAT);
   localparam int             DW         = $clog2(DRAIN + 1);
   localparam logic [AW-1:0]  LAST_SEL   = AW'(N * N - 1);
   localparam logic [DW-1:0]  DRAIN_INIT = DW'(DRAIN - 1);

   state_t             r_state;
   logic [K_WIDTH-1:0] r_k_len;
   logic [K_WIDTH-1:0] r_rd_addr;
   logic [DW-1:0]      r_drain_cnt;
   logic [3:0]         r_prec;
   logic [4:0]         r_exp;
   logic               r_busy;
   logic               r_done;
   logic               r_acc_clr;
   logic               r_rd_en;
   logic               r_out_valid;
   logic [AW-1:0]      r_acc_sel;
   logic [N-1:0]       w_row_valid;
   logic [N-1:0]       w_col_valid;

   // Outputs are registered alongside the state they belong to, so each one
   // is asserted for exactly the cycles its state is occupied.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= ST_IDLE;
         r_k_len     <= '0;
         r_rd_addr   <= '0;
         r_drain_cnt <= '0;
         r_prec      <= '0;
         r_exp       <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_acc_clr   <= 1'b0;
         r_rd_en     <= 1'b0;
         r_out_valid <= 1'b0;
         r_acc_sel   <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (bus.start) begin
                  r_k_len   <= bus.k_len;
                  r_prec    <= bus.precision;
                  r_exp     <= bus.exp_set;
                  r_busy    <= 1'b1;
                  r_acc_clr <= 1'b1;
                  r_state   <= ST_CLEAR;
               end
            end
            ST_CLEAR: begin
               r_acc_clr <= 1'b0;
               if (r_k_len != '0) begin
                  r_rd_en   <= 1'b1;
                  r_rd_addr <= '0;
                  r_state   <= ST_FEED;
               end else begin
                  r_drain_cnt <= DRAIN_INIT;
                  r_state     <= ST_DRAIN;
               end
            end
            ST_FEED: begin
               if (r_rd_addr == r_k_len - K_WIDTH'(1)) begin
                  r_rd_en     <= 1'b0;
                  r_drain_cnt <= DRAIN_INIT;
                  r_state     <= ST_DRAIN;
               end else begin
                  r_rd_addr <= r_rd_addr + K_WIDTH'(1);
               end
            end
            ST_DRAIN: begin
               if (r_drain_cnt == '0) begin
                  r_out_valid <= 1'b1;
                  r_acc_sel   <= '0;
                  r_state     <= ST_WB;
               end else begin
                  r_drain_cnt <= r_drain_cnt - DW'(1);
               end
            end
            ST_WB: begin
               if (bus.out_ready) begin
                  if (r_acc_sel == LAST_SEL) begin
                     r_out_valid <= 1'b0;
                     r_done      <= 1'b1;
                     r_state     <= ST_DONE;
                  end else begin
                     r_acc_sel <= r_acc_sel + AW'(1);
                  end
               end
            end
            ST_DONE: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   skew_shift #(.N(N)) u_row_skew (
      .clk    (clk),
      .rst    (rst),
      .i_din  (r_rd_en),
      .o_taps (w_row_valid)
   );

   skew_shift #(.N(N)) u_col_skew (
      .clk    (clk),
      .rst    (rst),
      .i_din  (r_rd_en),
      .o_taps (w_col_valid)
   );

`ifdef SYSTOLIC_CTRL_PERF_EN
   logic [31:0] r_perf_cyc;
   logic [31:0] r_perf_stall;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_perf_cyc   <= '0;
         r_perf_stall <= '0;
      end else if (r_state == ST_IDLE && bus.start) begin
         r_perf_cyc   <= '0;
         r_perf_stall <= '0;
      end else begin
         if (r_busy && r_perf_cyc != '1) r_perf_cyc <= r_perf_cyc + 32'd1;
         if (r_state == ST_WB && !bus.out_ready && r_perf_stall != '1)
            r_perf_stall <= r_perf_stall + 32'd1;
      end
   end

   assign bus.perf_cyc   = r_perf_cyc;
   assign bus.perf_stall = r_perf_stall;
`endif

   assign bus.prec_cfg  = r_prec;
   assign bus.exp_cfg   = r_exp;
   assign bus.busy      = r_busy;
   assign bus.done      = r_done;
   assign bus.acc_clr   = r_acc_clr;
   assign bus.rd_en     = r_rd_en;
   assign bus.rd_addr   = r_rd_addr;
   assign bus.row_valid = w_row_valid;
   assign bus.col_valid = w_col_valid;
   assign bus.out_valid = r_out_valid;
   assign bus.acc_sel   = r_acc_sel;
   assign bus.dbg_state = r_state;

endmodule
